// File: rtl/pix_stream_reader_pkg.sv
// Shared accelerator package: pixel/dimension widths and reader FSM states.
// Also consumed by the FIFO, so widths here set the FIFO data port.
package pix_stream_reader_pkg;

   localparam int D_WIDTH  = 8;
   localparam int DIM_BITS = 12;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } pix_state_e;

endpackage

// File: rtl/pix_stream_reader_if.sv
// FIFO-side and kernel-side handshake bundle for the pixel stream reader.
interface pix_stream_reader_if #(
   parameter int D_WIDTH = pix_stream_reader_pkg::D_WIDTH
) ();
   import pix_stream_reader_pkg::*;

   logic               data_valid;
   logic [D_WIDTH-1:0] mstr0_data;
   logic               fifo_empty;
   logic               mstr0_ready;
   logic [D_WIDTH-1:0] pix_data;
   logic               pix_valid;
   logic               pix_ready;
   logic               sof;
   logic               eol;
   logic               eof;

   modport slave (
      input  data_valid, mstr0_data, fifo_empty, pix_ready,
      output mstr0_ready, pix_data, pix_valid, sof, eol, eof
   );

   modport master (
      output data_valid, mstr0_data, fifo_empty, pix_ready,
      input  mstr0_ready, pix_data, pix_valid, sof, eol, eof
   );

endinterface

// File: rtl/pix_stream_reader_skid.sv
// Two-entry buffer: output register plus one skid entry.
module pix_skid_buf #(
   parameter int W = pix_stream_reader_pkg::D_WIDTH
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid_i,
   input  logic [W-1:0] in_data_i,
   input  logic         out_ready_i,
   output logic         out_valid_o,
   output logic [W-1:0] out_data_o,
   output logic         skid_nxt_o
);
   import pix_stream_reader_pkg::*;

   logic         ov_q, ov_d;
   logic         sv_q, sv_d;
   logic [W-1:0] od_q, od_d;
   logic [W-1:0] sd_q, sd_d;
   logic         out_free;

   assign out_free = !ov_q || out_ready_i;

   always_comb begin
      ov_d = ov_q;
      sv_d = sv_q;
      od_d = od_q;
      sd_d = sd_q;
      if (out_free) begin
         if (sv_q) begin
            // skid word advances; a new word may refill the skid
            od_d = sd_q;
            ov_d = 1'b1;
            sv_d = in_valid_i;
            if (in_valid_i) sd_d = in_data_i;
         end else if (in_valid_i) begin
            od_d = in_data_i;
            ov_d = 1'b1;
         end else begin
            ov_d = 1'b0;
         end
      end else if (in_valid_i) begin
         sv_d = 1'b1;
         sd_d = in_data_i;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ov_q <= 1'b0;
         sv_q <= 1'b0;
         od_q <= '0;
         sd_q <= '0;
      end else begin
         ov_q <= ov_d;
         sv_q <= sv_d;
         od_q <= od_d;
         sd_q <= sd_d;
      end
   end

   assign out_valid_o = ov_q;
   assign out_data_o  = od_q;
   assign skid_nxt_o  = sv_d;

endmodule

// File: rtl/pix_stream_reader.sv
// Frame reader: pulls FIFO words, tags sof/eol/eof, feeds the kernel.
module pix_stream_reader #(
   parameter int D_WIDTH  = pix_stream_reader_pkg::D_WIDTH,
   parameter int DIM_BITS = pix_stream_reader_pkg::DIM_BITS
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                start,
   input  logic [DIM_BITS-1:0] img_width,
   input  logic [DIM_BITS-1:0] img_height,
   pix_stream_reader_if.slave  bus,
   output logic                busy,
   output logic                done,
   output logic                err_underflow
);
   import pix_stream_reader_pkg::*;

   localparam logic [1:0] S_IDLE = ST_IDLE;
   localparam logic [1:0] S_RUN  = ST_RUN;
   localparam logic [1:0] S_DONE = ST_DONE;
   localparam int         CW     = 2 * DIM_BITS;

   logic [1:0]          state_q, state_d;
   logic [DIM_BITS-1:0] w_q, w_d, h_q, h_d;
   logic [DIM_BITS-1:0] col_q, col_d, row_q, row_d;
   logic [CW-1:0]       acc_q, acc_d, tot_q, tot_d;
   logic                rdy_q, rdy_d, err_q, err_d;
   logic                start_ok, zero_dim;
   logic                acc_xfer, pix_xfer, skid_nxt, out_v;
   logic [D_WIDTH-1:0]  out_d;
   logic                is_eol, is_eof;

   assign start_ok = start && (state_q == S_IDLE);
   assign zero_dim = (img_width == '0) || (img_height == '0);
   assign acc_xfer = bus.data_valid && rdy_q;
   assign pix_xfer = out_v && bus.pix_ready;
   assign is_eol   = col_q == (w_q - DIM_BITS'(1));
   assign is_eof   = is_eol && (row_q == (h_q - DIM_BITS'(1)));

   pix_skid_buf #(
      .W(D_WIDTH)
   ) u_buf (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid_i  (acc_xfer),
      .in_data_i   (bus.mstr0_data),
      .out_ready_i (bus.pix_ready),
      .out_valid_o (out_v),
      .out_data_o  (out_d),
      .skid_nxt_o  (skid_nxt)
   );

   always_comb begin
      state_d = state_q;
      w_d     = w_q;
      h_d     = h_q;
      col_d   = col_q;
      row_d   = row_q;
      tot_d   = tot_q;
      acc_d   = acc_q + CW'(acc_xfer);
      err_d   = start_ok ? 1'b0 : err_q;
      if (bus.data_valid && bus.fifo_empty) err_d = 1'b1;
      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               if (zero_dim) begin
                  state_d = S_DONE;
               end else begin
                  state_d = S_RUN;
                  w_d     = img_width;
                  h_d     = img_height;
                  tot_d   = CW'(img_width) * CW'(img_height);
                  acc_d   = '0;
                  col_d   = '0;
                  row_d   = '0;
               end
            end
         end
         S_RUN: begin
            if (pix_xfer) begin
               if (is_eol) begin
                  col_d = '0;
                  row_d = row_q + DIM_BITS'(1);
               end else begin
                  col_d = col_q + DIM_BITS'(1);
               end
               if (is_eof) state_d = S_DONE;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      // ready only when a word has a guaranteed landing slot
      rdy_d = (state_d == S_RUN) && !skid_nxt && (acc_d < tot_d);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         w_q     <= '0;
         h_q     <= '0;
         col_q   <= '0;
         row_q   <= '0;
         acc_q   <= '0;
         tot_q   <= '0;
         rdy_q   <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         w_q     <= w_d;
         h_q     <= h_d;
         col_q   <= col_d;
         row_q   <= row_d;
         acc_q   <= acc_d;
         tot_q   <= tot_d;
         rdy_q   <= rdy_d;
         err_q   <= err_d;
      end
   end

   assign bus.mstr0_ready = rdy_q;
   assign bus.pix_valid   = out_v;
   assign bus.pix_data    = out_d;
   assign bus.sof         = out_v && (col_q == '0) && (row_q == '0);
   assign bus.eol         = out_v && is_eol;
   assign bus.eof         = out_v && is_eof;
   assign busy            = state_q == S_RUN;
   assign done            = state_q == S_DONE;
   assign err_underflow   = err_q;

endmodule

// File: tb/tb_pix_stream_reader.sv
// Scoreboard bench for pix_stream_reader: FIFO model, kernel monitor, directed frames.
module tb_pix_stream_reader;

   localparam int DW = 8;
   localparam int DB = 12;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic [DB-1:0] img_width = '0;
   logic [DB-1:0] img_height = '0;
   logic          busy, done, err_underflow;

   pix_stream_reader_if #(.D_WIDTH(DW)) bus ();

   pix_stream_reader #(
      .D_WIDTH  (DW),
      .DIM_BITS (DB)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .start         (start),
      .img_width     (img_width),
      .img_height    (img_height),
      .bus           (bus),
      .busy          (busy),
      .done          (done),
      .err_underflow (err_underflow)
   );

   always #5 clk = ~clk;

   logic [7:0]  fifo_q[$];
   logic [10:0] exp_q[$];
   int          total = 0;
   int          passed = 0;
   int          cyc = 0;
   int          eof_cyc = -10;
   int          pix_cnt = 0;
   bit          pend = 1'b0;
   bit          force_uf = 1'b0;

   task automatic check(input string nm, input logic [31:0] act,
                        input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got 0x%0h required 0x%0h", nm, act, exp);
   endtask

   initial forever begin
      @(posedge clk);
      cyc <= cyc + 1;
   end

   // FIFO model: updates its outputs 2 time units after each edge
   initial forever begin
      @(posedge clk);
      #2;
      if (pend && fifo_q.size() > 0) void'(fifo_q.pop_front());
      pend = 1'b0;
      bus.data_valid = (fifo_q.size() > 0) || force_uf;
      bus.fifo_empty = fifo_q.size() == 0;
      bus.mstr0_data = (fifo_q.size() > 0) ? fifo_q[0] : '0;
   end

   initial forever begin
      @(negedge clk);
      pend = rst_n && bus.data_valid && bus.mstr0_ready;
   end

   // kernel-side monitor
   initial forever begin
      @(negedge clk);
      if (rst_n && bus.pix_valid && bus.pix_ready) begin
         pix_cnt++;
         if (bus.eof) eof_cyc = cyc;
         if (exp_q.size() == 0) begin
            total++;
            $display("FAIL sb_extra: got pixel 0x%0h required none",
                     bus.pix_data);
         end else begin
            check("sb_pixel",
                  32'({bus.pix_data, bus.sof, bus.eol, bus.eof}),
                  32'(exp_q.pop_front()));
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: got timeout required finish");
      $fatal(1);
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic load_frame(input int w, input int h,
                             input logic [7:0] base, input int extra);
      for (int i = 0; i < w * h + extra; i++)
         fifo_q.push_back(base + 8'(i));
      for (int i = 0; i < w * h; i++) begin
         bit s, e, f;
         s = (i == 0);
         e = (i % w) == w - 1;
         f = e && ((i / w) == h - 1);
         exp_q.push_back({base + 8'(i), s, e, f});
      end
   endtask

   task automatic start_frame(input int w, input int h);
      img_width  = DB'(w);
      img_height = DB'(h);
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   task automatic wait_done(input int budget, input bit chk);
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (done) begin
            ok = 1'b1;
            break;
         end
      end
      check("done_seen", 32'(ok), 32'd1);
      check("done_not_busy", 32'(busy), 32'd0);
      if (chk) check("done_after_eof", 32'(cyc), 32'(eof_cyc + 1));
   endtask

   initial begin
      bit seen;
      bus.pix_ready = 1'b1;
      repeat (2) step();
      @(negedge clk);
      check("reset_outputs",
            32'({bus.mstr0_ready, bus.pix_valid, bus.pix_data, bus.sof,
                 bus.eol, bus.eof, busy, done, err_underflow}), 32'd0);
      step();
      rst_n = 1'b1;
      step();

      // 4x2 frame with one surplus word left in the FIFO
      load_frame(4, 2, 8'h10, 1);
      start_frame(4, 2);
      @(negedge clk);
      check("t1_busy", 32'(busy), 32'd1);
      wait_done(60, 1'b1);
      @(negedge clk);
      check("t1_done_pulse", 32'({done, busy}), 32'd0);
      check("t1_surplus_kept", 32'(fifo_q.size()), 32'd1);
      check("t1_sb_empty", 32'(exp_q.size()), 32'd0);
      step();
      fifo_q.delete();

      // 3x1 frame with a stalled kernel
      bus.pix_ready = 1'b0;
      load_frame(3, 1, 8'h10, 0);
      start_frame(3, 1);
      seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (bus.pix_valid) begin
            seen = 1'b1;
            break;
         end
      end
      check("t2_first_valid", 32'(seen), 32'd1);
      for (int i = 0; i < 5; i++) begin
         check("t2_hold",
               32'({bus.pix_valid, bus.pix_data, bus.sof, bus.eol, bus.eof}),
               32'({1'b1, 8'h10, 1'b1, 1'b0, 1'b0}));
         @(negedge clk);
      end
      check("t2_ready_low", 32'(bus.mstr0_ready), 32'd0);
      step();
      bus.pix_ready = 1'b1;
      wait_done(40, 1'b1);
      check("t2_sb_empty", 32'(exp_q.size()), 32'd0);
      step();

      // zero width: immediate done, nothing taken from the FIFO
      fifo_q.push_back(8'hAA);
      fifo_q.push_back(8'hAB);
      start_frame(0, 5);
      @(negedge clk);
      check("t3_done", 32'(done), 32'd1);
      check("t3_busy", 32'(busy), 32'd0);
      check("t3_ready", 32'(bus.mstr0_ready), 32'd0);
      @(negedge clk);
      check("t3_after", 32'({done, busy, bus.mstr0_ready}), 32'd0);
      check("t3_fifo_untouched", 32'(fifo_q.size()), 32'd2);
      step();
      fifo_q.delete();

      // underflow flag: set, held, cleared by next start
      step();
      force_uf = 1'b1;
      step();
      force_uf = 1'b0;
      @(negedge clk);
      check("t4_err_set", 32'(err_underflow), 32'd1);
      repeat (3) @(negedge clk);
      check("t4_err_held", 32'(err_underflow), 32'd1);
      step();
      load_frame(2, 1, 8'h40, 0);
      start_frame(2, 1);
      @(negedge clk);
      check("t4_err_clr", 32'(err_underflow), 32'd0);
      wait_done(30, 1'b1);
      step();

      // reset after 3 of 8 pixels
      load_frame(4, 2, 8'h50, 0);
      pix_cnt = 0;
      start_frame(4, 2);
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (pix_cnt >= 3) break;
      end
      check("t5_three_pixels", 32'(pix_cnt), 32'd3);
      step();
      rst_n = 1'b0;
      bus.pix_ready = 1'b0;
      step();
      @(negedge clk);
      check("t5_reset_outputs",
            32'({bus.mstr0_ready, bus.pix_valid, bus.pix_data, bus.sof,
                 bus.eol, bus.eof, busy, done, err_underflow}), 32'd0);
      step();
      rst_n = 1'b1;
      bus.pix_ready = 1'b1;
      fifo_q.delete();
      exp_q.delete();
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("t5_no_done", 32'({done, busy}), 32'd0);
      end
      step();
      load_frame(2, 1, 8'h60, 0);
      start_frame(2, 1);
      wait_done(30, 1'b1);
      check("t5_sb_empty", 32'(exp_q.size()), 32'd0);
      step();

      // start during RUN with other dimensions is ignored
      load_frame(4, 2, 8'h70, 0);
      start_frame(4, 2);
      step();
      img_width  = DB'(2);
      img_height = DB'(1);
      start = 1'b1;
      step();
      start = 1'b0;
      @(negedge clk);
      check("t6_still_busy", 32'(busy), 32'd1);
      wait_done(60, 1'b1);
      check("t6_sb_empty", 32'(exp_q.size()), 32'd0);

      repeat (3) step();
      check("final_sb_empty", 32'(exp_q.size()), 32'd0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/pix_stream_reader.md
PIX_STREAM_READER -- requirements
Module: pix_stream_reader

Interface
REQ-001 SHALL have parameter D_WIDTH, default 8, pixel width matching the FIFO data port.
REQ-002 SHALL have parameter DIM_BITS, default 12, width of the frame-dimension and counter fields.
REQ-003 SHALL have one clock and a synchronous, active-low reset; no other clock or reset exists.
REQ-004 Ports, clock and reset first:
- clk  in  1  clock
- rst_n  in  1  reset
- start  in  1  frame start pulse
- img_width  in  DIM_BITS  pixels per line
- img_height  in  DIM_BITS  lines per frame
- data_valid  in  1  FIFO output word valid
- mstr0_data  in  D_WIDTH  FIFO output word
- fifo_empty  in  1  FIFO empty flag
- mstr0_ready  out  1  reader accepts word
- pix_data  out  D_WIDTH  pixel to kernel
- pix_valid  out  1  pixel valid
- pix_ready  in  1  kernel accepts pixel
- sof  out  1  first pixel of frame
- eol  out  1  last pixel of line
- eof  out  1  last pixel of frame
- busy  out  1  frame in progress
- done  out  1  one-cycle frame-complete pulse
- err_underflow  out  1  sticky protocol error

Function
REQ-005 FIFO-side transfer SHALL occur on a rising edge where data_valid && mstr0_ready; kernel-side transfer SHALL occur where pix_valid && pix_ready.
REQ-006 mstr0_ready SHALL be registered and high only when all three hold: state is RUN, the skid entry is empty, and accepted count < img_width*img_height as latched.
REQ-007 SHALL buffer accepted words in two entries: an output register (drives pix_*) and one skid entry; no word is dropped or duplicated.
REQ-008 An accepted word SHALL go to the output register if it is empty or draining that cycle, otherwise to the skid entry. When the output register drains, the skid word moves into it the same edge.
REQ-009 Latency from FIFO transfer to pix_valid SHALL be 1 cycle when the output register is free.
REQ-010 pix_data, pix_valid, sof, eol and eof SHALL stay stable while pix_valid && !pix_ready.
REQ-011 sof SHALL be high with the pixel at col 0, row 0. eol SHALL be high with the pixel at col img_width-1. eof SHALL be high with the pixel at col img_width-1, row img_height-1.
REQ-012 The output-side col counter SHALL wrap to 0 and row SHALL increment on an eol transfer.
REQ-013 FSM states IDLE, RUN and DONE:
- IDLE->RUN on start with both dimensions nonzero; img_width and img_height are latched then.
- IDLE->DONE on start with either dimension zero; no pixels are produced.
- RUN->DONE on the eof kernel transfer.
- DONE->IDLE after 1 cycle; done=1 only in DONE.
REQ-014 busy SHALL be 1 in RUN, 0 otherwise. start SHALL be ignored outside IDLE.
REQ-015 err_underflow SHALL set when data_valid && fifo_empty in any cycle. It SHALL clear only on an accepted start or on reset.
REQ-016 The accepted count SHALL be DIM_BITS*2 wide. The product img_width*img_height SHALL be computed at full width with no truncation.
REQ-017 Words presented beyond the frame total SHALL NOT be accepted; mstr0_ready stays 0.

Reset
REQ-018 While rst_n=0 at a clock edge:
- FSM goes to IDLE.
- Both buffer entries are emptied and their contents discarded.
- Counters clear.
- All outputs are 0: mstr0_ready, pix_valid, pix_data, sof, eol, eof, busy, done, err_underflow.
REQ-019 Reset asserted mid-frame SHALL abort the frame with no done pulse. The next frame requires a new start.

Structure
REQ-020 D_WIDTH, DIM_BITS and the FSM state enum SHALL reside in the shared accelerator package, also used by the FIFO.
REQ-021 The two-entry buffer SHALL be a sub-module, pix_skid_buf. Counters, markers and the FSM stay in the top level.

Verification
REQ-022 4x2 frame, data_valid always high, pix_ready always high, data 0x10..0x17 -> 8 pixels in order. sof on 0x10; eol on 0x13 and 0x17; eof on 0x17. done 1 cycle after the eof transfer.
REQ-023 3x1 frame, pix_ready low for 5 cycles after the first pixel -> mstr0_ready drops after the skid entry fills. Output holds 0x10 and markers steady. No loss when pix_ready returns.
REQ-024 img_width=0, start pulse -> done pulses the next cycle, busy never rises, mstr0_ready stays 0.
REQ-025 data_valid=1 with fifo_empty=1 for one cycle -> err_underflow=1 and held. The next start clears it.
REQ-026 Reset mid-frame after 3 of 8 pixels -> all outputs 0 next cycle, no done pulse. A following 2x1 frame completes normally.
REQ-027 Start pulsed during RUN with different dimensions -> ignored. The original frame's eof position is unchanged.
